dram_cmd_buffer: RTL and testbench



---
 rtl/dram_cmd_buffer_if.sv | 44 ++++
 rtl/dram_cmd_buffer.sv | 101 ++++++++++
 tb/tb_dram_cmd_buffer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_cmd_buffer_if.sv
// Core-side request/response and DRAM-wrapper command/read-return signals of dram_cmd_buffer.
// The slave modport is the buffer's view; master is the view of whoever drives it.
interface dram_cmd_buffer_if #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
);
  // core side
  logic                      i_ren;
  logic                      i_wen;
  logic [APP_ADDR_WIDTH-2:0] i_addr;
  logic [APP_DATA_WIDTH-1:0] i_wdata;
  logic [APP_MASK_WIDTH-1:0] i_wmask;
  logic                      o_busy;
  logic [APP_DATA_WIDTH-1:0] o_rdata;
  logic                      o_rdata_valid;
  // DRAM wrapper side
  logic                      o_dram_ren;
  logic                      o_dram_wen;
  logic [APP_ADDR_WIDTH-2:0] o_dram_addr;
  logic [APP_DATA_WIDTH-1:0] o_dram_wdata;
  logic [APP_MASK_WIDTH-1:0] o_dram_wmask;
  logic                      i_dram_busy;
  logic                      i_dram_init_calib_complete;
  logic [APP_DATA_WIDTH-1:0] i_dram_rdata;
  logic                      i_dram_rdata_valid;
  logic                      o_err;

  modport slave (
    input  i_ren, i_wen, i_addr, i_wdata, i_wmask,
    input  i_dram_busy, i_dram_init_calib_complete, i_dram_rdata, i_dram_rdata_valid,
    output o_busy, o_rdata, o_rdata_valid,
    output o_dram_ren, o_dram_wen, o_dram_addr, o_dram_wdata, o_dram_wmask,
    output o_err
  );

  modport master (
    output i_ren, i_wen, i_addr, i_wdata, i_wmask,
    output i_dram_busy, i_dram_init_calib_complete, i_dram_rdata, i_dram_rdata_valid,
    input  o_busy, o_rdata, o_rdata_valid,
    input  o_dram_ren, o_dram_wen, o_dram_addr, o_dram_wdata, o_dram_wmask,
    input  o_err
  );
endinterface

// File: rtl/dram_cmd_buffer.sv
// In-order command FIFO between the core and the DRAM wrapper: gates issue on calibration,
// limits outstanding reads to MAX_RD, and registers read data back to the core.
module dram_cmd_buffer #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int DEPTH          = 4,
  parameter int MAX_RD         = 4
) (
  input  logic               clock,
  input  logic               resetn,
  dram_cmd_buffer_if.slave   bus
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [3:0]  MAX_RD_C = 4'(MAX_RD);

  typedef struct packed {
    logic                      is_write;
    logic [APP_ADDR_WIDTH-2:0] addr;
    logic [APP_DATA_WIDTH-1:0] wdata;
    logic [APP_MASK_WIDTH-1:0] wmask;
  } entry_t;

  entry_t                    r_mem [DEPTH];
  logic [PW:0]               r_wr_ptr;
  logic [PW:0]               r_rd_ptr;
  logic [3:0]                r_rd_cnt;
  logic [APP_DATA_WIDTH-1:0] r_rdata;
  logic                      r_rdata_valid;
  logic                      r_err;

  logic   w_full, w_empty, w_calib, w_busy;
  logic   w_req, w_push, w_pop;
  logic   w_issue_rd, w_issue_wr;
  logic   w_rd_inc, w_rd_dec, w_err_set;
  entry_t w_head, w_new;

  assign w_calib = bus.i_dram_init_calib_complete;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_busy  = w_full | ~w_calib;

  assign w_req   = bus.i_ren | bus.i_wen;
  assign w_push  = w_req & ~w_busy;
  // A simultaneous read+write request keeps the write and drops the read.
  assign w_new   = '{is_write: bus.i_wen, addr: bus.i_addr, wdata: bus.i_wdata, wmask: bus.i_wmask};

  assign w_head     = r_mem[r_rd_ptr[PW-1:0]];
  assign w_issue_wr = ~w_empty & w_calib & w_head.is_write;
  assign w_issue_rd = ~w_empty & w_calib & ~w_head.is_write & (r_rd_cnt < MAX_RD_C);
  assign w_pop      = (w_issue_rd | w_issue_wr) & ~bus.i_dram_busy;

  assign w_rd_inc  = w_issue_rd & ~bus.i_dram_busy;
  assign w_rd_dec  = bus.i_dram_rdata_valid & (r_rd_cnt != 4'd0);
  assign w_err_set = (bus.i_ren & bus.i_wen) | (w_req & w_busy) |
                     (bus.i_dram_rdata_valid & (r_rd_cnt == 4'd0));

  // NOTE: the storage array has no reset; validity comes solely from the pointers,
  // which keeps the RAM free of reset fan-out.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= w_new;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rd_cnt      <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_rd_inc, w_rd_dec})
        2'b10:   r_rd_cnt <= r_rd_cnt + 4'd1;
        2'b01:   r_rd_cnt <= r_rd_cnt - 4'd1;
        default: r_rd_cnt <= r_rd_cnt;
      endcase

      r_rdata_valid <= bus.i_dram_rdata_valid;
      if (bus.i_dram_rdata_valid) r_rdata <= bus.i_dram_rdata;

      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign bus.o_busy        = w_busy;
  assign bus.o_rdata       = r_rdata;
  assign bus.o_rdata_valid = r_rdata_valid;
  assign bus.o_dram_ren    = w_issue_rd;
  assign bus.o_dram_wen    = w_issue_wr;
  assign bus.o_dram_addr   = w_head.addr;
  assign bus.o_dram_wdata  = w_head.wdata;
  assign bus.o_dram_wmask  = w_head.wmask;
  assign bus.o_err         = r_err;

endmodule

// File: tb/tb_dram_cmd_buffer.sv
// Directed bench for dram_cmd_buffer (DEPTH=4, MAX_RD=2): calibration gating, back-pressure,
// read limit, read+write collision, stray read data and mid-operation reset.
module tb_dram_cmd_buffer;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;

  logic clock;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  dram_cmd_buffer_if #(.APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW)) bus ();

  dram_cmd_buffer #(
    .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW), .DEPTH(4), .MAX_RD(2)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_ren = 1'b0;
    bus.i_wen = 1'b0;
    bus.i_addr = '0;
    bus.i_wdata = '0;
    bus.i_wmask = '0;
    bus.i_dram_rdata = '0;
    bus.i_dram_rdata_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    bus.i_dram_busy = 1'b0;
    bus.i_dram_init_calib_complete = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;

    // ---- 1. reset state and calibration gating
    check("rst_err",    128'(bus.o_err), 128'(0));
    check("rst_rvalid", 128'(bus.o_rdata_valid), 128'(0));
    check("rst_rdata",  128'(bus.o_rdata), 128'(0));
    check("rst_wen",    128'(bus.o_dram_wen), 128'(0));
    check("rst_ren",    128'(bus.o_dram_ren), 128'(0));
    check("nocal_busy", 128'(bus.o_busy), 128'(1));

    bus.i_wen = 1'b1;
    bus.i_addr = 27'h10;
    tick();
    idle_inputs();
    #1;
    check("nocal_err",  128'(bus.o_err), 128'(1));
    bus.i_dram_init_calib_complete = 1'b1;
    #1;
    check("nocal_noenq", 128'(bus.o_dram_wen), 128'(0));
    check("cal_busy",    128'(bus.o_busy), 128'(0));

    resetn = 1'b0;
    #1;
    check("rst_err_clr", 128'(bus.o_err), 128'(0));
    tick();
    resetn = 1'b1;
    bus.i_wen = 1'b1;
    bus.i_addr = 27'h10;
    bus.i_wdata = {16{8'hA5}};
    bus.i_wmask = 16'hFFFF;
    tick();
    idle_inputs();
    #1;
    check("t1_wen",   128'(bus.o_dram_wen), 128'(1));
    check("t1_addr",  128'(bus.o_dram_addr), 128'(27'h10));
    check("t1_wdata", bus.o_dram_wdata, {16{8'hA5}});
    check("t1_wmask", 128'(bus.o_dram_wmask), 128'(16'hFFFF));
    tick();
    check("t1_popped", 128'(bus.o_dram_wen), 128'(0));

    // ---- 2. back-pressure: fill while wrapper busy, then drain one per cycle
    bus.i_dram_busy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.i_wen = 1'b1;
      bus.i_addr = 27'(k);
      bus.i_wdata = 128'(k);
      tick();
    end
    idle_inputs();
    #1;
    check("t2_full_busy", 128'(bus.o_busy), 128'(1));
    check("t2_hold_addr", 128'(bus.o_dram_addr), 128'(1));
    bus.i_dram_busy = 1'b0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      check("t2_wen",   128'(bus.o_dram_wen), 128'(1));
      check("t2_addr",  128'(bus.o_dram_addr), 128'(k));
      check("t2_wdata", bus.o_dram_wdata, 128'(k));
      if (k == 1) check("t2_busy_full", 128'(bus.o_busy), 128'(1));
      else        check("t2_busy_drop", 128'(bus.o_busy), 128'(0));
      tick();
    end
    check("t2_drained", 128'(bus.o_dram_wen), 128'(0));

    // ---- 3. read limit (MAX_RD = 2)
    for (int k = 0; k < 3; k++) begin
      bus.i_ren = 1'b1;
      bus.i_addr = 27'(32'h30 + k);
      tick();
    end
    idle_inputs();
    #1;
    check("t3_held_ren",  128'(bus.o_dram_ren), 128'(0));
    check("t3_held_addr", 128'(bus.o_dram_addr), 128'(27'h32));
    tick();
    check("t3_still_held", 128'(bus.o_dram_ren), 128'(0));
    bus.i_dram_rdata = 128'h1234;
    bus.i_dram_rdata_valid = 1'b1;
    #1;
    check("t3_no_early", 128'(bus.o_rdata_valid), 128'(0));
    tick();
    idle_inputs();
    #1;
    check("t3_rvalid",  128'(bus.o_rdata_valid), 128'(1));
    check("t3_rdata",   bus.o_rdata, 128'h1234);
    check("t3_rd3_ren", 128'(bus.o_dram_ren), 128'(1));
    check("t3_rd3_addr", 128'(bus.o_dram_addr), 128'(27'h32));
    tick();
    check("t3_pulse_end", 128'(bus.o_rdata_valid), 128'(0));
    check("t3_rdata_hold", bus.o_rdata, 128'h1234);
    check("t3_empty",     128'(bus.o_dram_ren), 128'(0));
    for (int k = 1; k <= 2; k++) begin
      bus.i_dram_rdata = 128'(k);
      bus.i_dram_rdata_valid = 1'b1;
      tick();
    end
    idle_inputs();
    tick();
    check("t3_no_err", 128'(bus.o_err), 128'(0));
    check("t3_rdata_last", bus.o_rdata, 128'(2));

    // ---- 4. simultaneous read and write
    bus.i_ren = 1'b1;
    bus.i_wen = 1'b1;
    bus.i_addr = 27'h20;
    bus.i_wdata = 128'h77;
    tick();
    idle_inputs();
    #1;
    check("t4_wen",  128'(bus.o_dram_wen), 128'(1));
    check("t4_ren",  128'(bus.o_dram_ren), 128'(0));
    check("t4_addr", 128'(bus.o_dram_addr), 128'(27'h20));
    check("t4_err",  128'(bus.o_err), 128'(1));
    tick();
    check("t4_no_read_wen", 128'(bus.o_dram_wen), 128'(0));
    check("t4_no_read_ren", 128'(bus.o_dram_ren), 128'(0));

    // ---- 5. stray read data with nothing outstanding
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    check("t5_err_clr", 128'(bus.o_err), 128'(0));
    bus.i_dram_rdata = 128'hBEEF;
    bus.i_dram_rdata_valid = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("t5_rvalid", 128'(bus.o_rdata_valid), 128'(1));
    check("t5_rdata",  bus.o_rdata, 128'hBEEF);
    check("t5_err",    128'(bus.o_err), 128'(1));
    // rd_cnt stayed 0: two reads must both issue before the limit blocks a third
    for (int k = 0; k < 3; k++) begin
      bus.i_ren = 1'b1;
      bus.i_addr = 27'(32'h40 + k);
      tick();
      if (k == 0) check("t5_rd0_issue", 128'(bus.o_dram_ren), 128'(1));
      if (k == 1) check("t5_rd1_issue", 128'(bus.o_dram_ren), 128'(1));
    end
    idle_inputs();
    #1;
    check("t5_rd2_held", 128'(bus.o_dram_ren), 128'(0));

    // ---- 6. reset with queued commands
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    bus.i_dram_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.i_wen = (k < 2);
      bus.i_ren = (k == 2);
      bus.i_addr = 27'(32'h50 + k);
      tick();
    end
    idle_inputs();
    #1;
    check("t6_queued_wen", 128'(bus.o_dram_wen), 128'(1));
    resetn = 1'b0;
    #1;
    check("t6_rst_wen",  128'(bus.o_dram_wen), 128'(0));
    check("t6_rst_ren",  128'(bus.o_dram_ren), 128'(0));
    tick();
    resetn = 1'b1;
    bus.i_dram_busy = 1'b0;
    #1;
    check("t6_post_wen",  128'(bus.o_dram_wen), 128'(0));
    check("t6_post_ren",  128'(bus.o_dram_ren), 128'(0));
    check("t6_post_busy", 128'(bus.o_busy), 128'(0));
    tick();
    check("t6_idle_wen", 128'(bus.o_dram_wen), 128'(0));
    check("t6_idle_ren", 128'(bus.o_dram_ren), 128'(0));
    bus.i_dram_init_calib_complete = 1'b0;
    #1;
    check("t6_nocal_busy", 128'(bus.o_busy), 128'(1));
    bus.i_dram_init_calib_complete = 1'b1;
    #1;
    check("t6_cal_busy", 128'(bus.o_busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
